// File: rtl/adc_stream_packer_pkg.sv
// Shared definitions for the ADC stream packer.
//   wr_state_t   : writer FSM encoding (IDLE, WRITE, FLUSH)
//   FX2_EP_ADDR  : constant endpoint select driven on FIFOADR
//   MARK_BIT/OTR_BIT : low-bit positions inside a packed 16-bit word
//   pack_word()  : builds one FX2 word from a sample, marker and OTR bit
package adc_stream_packer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_FLUSH = 2'd2
  } wr_state_t;

  localparam logic [1:0] FX2_EP_ADDR = 2'b10;
  localparam int MARK_BIT = 1;
  localparam int OTR_BIT  = 0;

  // Sample is passed zero-extended to 14 bits; shifting by (16 - sample_w)
  // places its MSB at bit 15. Bits below the sample stay 0 apart from the
  // frame marker and OTR flag.
  function automatic logic [15:0] pack_word(input logic [13:0] sample,
                                            input int sample_w,
                                            input logic marker,
                                            input logic otr);
    logic [15:0] w;
    w = {2'b00, sample} << (16 - sample_w);
    w[MARK_BIT] = marker;
    w[OTR_BIT]  = otr;
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push, din  : write din this cycle (ignored when full)
//   pop, dout  : dout is the head word; pop consumes it (ignored when empty)
//   empty, full, level : occupancy status, level counts stored words
// Handshake: push acts as valid with !full as ready, pop acts as ready with
// !empty as valid; a transfer happens only in a cycle where both are high.
module sync_fifo #(
  parameter int DEPTH = 512,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      // Simultaneous push and pop leaves the level unchanged.
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/adc_stream_packer.sv
// Captures multi-channel ADC frames at a programmable rate, packs each
// sample into a 16-bit word and streams the words to an FX2 slave FIFO.
// Ports:
//   ADC_CLK, RST_N : single clock, asynchronous active-low reset
//   EN, DECIM      : capture enable, capture period minus one (cycles)
//   D_IN, OTR      : per-channel samples (ch0 in LSBs) and out-of-range bits
//   FX2_FLAGB      : endpoint has room (1 = room)
//   FD_OUT, FX2_SLWR, FX2_PKTEND, FIFOADR : FX2 write interface
//   OVERFLOW, DROP_CNT : sticky drop flag, saturating dropped-frame count
//   dbg_state      : writer FSM state
module adc_stream_packer
  import adc_stream_packer_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int SAMPLE_W  = 14,
  parameter int DEPTH     = 512,
  parameter int PKT_WORDS = 256
) (
  input  logic                        ADC_CLK,
  input  logic                        RST_N,
  input  logic                        EN,
  input  logic [7:0]                  DECIM,
  input  logic [NUM_CH*SAMPLE_W-1:0]  D_IN,
  input  logic [NUM_CH-1:0]           OTR,
  input  logic                        FX2_FLAGB,
  output logic [15:0]                 FD_OUT,
  output logic                        FX2_SLWR,
  output logic                        FX2_PKTEND,
  output logic [1:0]                  FIFOADR,
  output logic                        OVERFLOW,
  output logic [15:0]                 DROP_CNT,
  output wr_state_t                   dbg_state
);
  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PC_W  = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;

  // ---------------- capture side ----------------
  logic [8:0]          period;
  logic [8:0]          tick_cnt;
  logic                tick;
  logic                accept;
  logic                busy;
  logic [IDX_W-1:0]    idx;
  logic [SAMPLE_W-1:0] smp_q [NUM_CH];
  logic [NUM_CH-1:0]   otr_q;
  logic [31:0]         pending;
  logic [31:0]         used;

  logic [15:0]         fifo_din;
  logic [15:0]         fifo_dout;
  logic                fifo_empty;
  logic                fifo_full;
  logic [LVL_W-1:0]    fifo_level;
  logic                push;
  logic                pop;

  always_comb begin
    period = {1'b0, DECIM} + 9'd1;
    if (period < 9'(NUM_CH)) period = 9'(NUM_CH);
  end

  // Counter sits at 0 while EN is low, so a tick fires on the first enabled cycle.
  assign tick = EN && (tick_cnt == 9'd0);

  // Free space must also cover words of the previous frame not yet pushed,
  // including the one being pushed this cycle.
  always_comb begin
    pending = busy ? (32'(NUM_CH) - 32'(idx)) : 32'd0;
    used    = 32'(fifo_level) + pending;
  end
  assign accept = tick && ((used + 32'(NUM_CH)) <= 32'(DEPTH));

  assign push     = busy && !fifo_full;
  assign fifo_din = pack_word(14'(smp_q[idx]), SAMPLE_W, (idx == '0), otr_q[idx]);

  always_ff @(posedge ADC_CLK or negedge RST_N) begin
    if (!RST_N) begin
      tick_cnt <= '0;
      busy     <= 1'b0;
      idx      <= '0;
      otr_q    <= '0;
      OVERFLOW <= 1'b0;
      DROP_CNT <= '0;
      for (int c = 0; c < NUM_CH; c++) smp_q[c] <= '0;
    end else begin
      if (!EN || (tick_cnt >= period - 9'd1)) tick_cnt <= '0;
      else                                    tick_cnt <= tick_cnt + 9'd1;

      if (busy) begin
        if (idx == IDX_W'(NUM_CH - 1)) busy <= 1'b0;
        else                           idx  <= idx + 1'b1;
      end
      // A new frame may start in the cycle the previous one pushes its last word.
      if (accept) begin
        busy  <= 1'b1;
        idx   <= '0;
        otr_q <= OTR;
        for (int c = 0; c < NUM_CH; c++) smp_q[c] <= D_IN[c*SAMPLE_W +: SAMPLE_W];
      end
      if (tick && !accept) begin
        OVERFLOW <= 1'b1;
        if (DROP_CNT != 16'hFFFF) DROP_CNT <= DROP_CNT + 16'd1;
      end
    end
  end

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(16)) u_fifo (
    .clk   (ADC_CLK),
    .rst_n (RST_N),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (fifo_level)
  );

  // ---------------- FX2 writer ----------------
  wr_state_t        state_q, state_d;
  logic [PC_W-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic [15:0]      fd_d;
  logic             slwr_d;
  logic             pktend_d;

  always_comb begin
    state_d   = state_q;
    pkt_cnt_d = pkt_cnt_q;
    fd_d      = FD_OUT;
    slwr_d    = 1'b1;
    pktend_d  = 1'b1;
    pop       = 1'b0;
    case (state_q)
      // IDLE pops on its exit cycle so the first word costs no extra cycle.
      ST_IDLE: begin
        if (!fifo_empty && FX2_FLAGB) begin
          pop     = 1'b1;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (!fifo_empty && FX2_FLAGB) begin
          pop = 1'b1;
        end else if (fifo_empty && !EN && !busy && (pkt_cnt_q != '0)) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        pktend_d  = 1'b0;
        pkt_cnt_d = '0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (pop) begin
      fd_d      = fifo_dout;
      slwr_d    = 1'b0;
      // Full packets are committed by the FX2 itself; just wrap.
      pkt_cnt_d = (pkt_cnt_q == PC_W'(PKT_WORDS - 1)) ? '0 : pkt_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge ADC_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      pkt_cnt_q  <= '0;
      FD_OUT     <= '0;
      FX2_SLWR   <= 1'b1;
      FX2_PKTEND <= 1'b1;
    end else begin
      state_q    <= state_d;
      pkt_cnt_q  <= pkt_cnt_d;
      FD_OUT     <= fd_d;
      FX2_SLWR   <= slwr_d;
      FX2_PKTEND <= pktend_d;
    end
  end

  assign FIFOADR   = FX2_EP_ADDR;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_adc_stream_packer.sv
// Bench for adc_stream_packer (default parameters: 2 channels, 14-bit
// samples, 512-word FIFO, 256-word packets).
module tb_adc_stream_packer;
  import adc_stream_packer_pkg::*;

  localparam int NC   = 2;
  localparam int SW   = 14;
  localparam int DEP  = 512;
  localparam int PKTW = 256;

  // ---------------- clock / reset ----------------
  logic ADC_CLK;
  logic RST_N;
  initial ADC_CLK = 1'b0;
  always #5 ADC_CLK = ~ADC_CLK;

  logic              EN;
  logic [7:0]        DECIM;
  logic [NC*SW-1:0]  D_IN;
  logic [NC-1:0]     OTR;
  logic              FX2_FLAGB;
  logic [15:0]       FD_OUT;
  logic              FX2_SLWR;
  logic              FX2_PKTEND;
  logic [1:0]        FIFOADR;
  logic              OVERFLOW;
  logic [15:0]       DROP_CNT;
  wr_state_t         dbg_state;

  adc_stream_packer dut (
    .ADC_CLK    (ADC_CLK),
    .RST_N      (RST_N),
    .EN         (EN),
    .DECIM      (DECIM),
    .D_IN       (D_IN),
    .OTR        (OTR),
    .FX2_FLAGB  (FX2_FLAGB),
    .FD_OUT     (FD_OUT),
    .FX2_SLWR   (FX2_SLWR),
    .FX2_PKTEND (FX2_PKTEND),
    .FIFOADR    (FIFOADR),
    .OVERFLOW   (OVERFLOW),
    .DROP_CNT   (DROP_CNT),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  int          obs_t[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          pktend_cnt = 0;
  int          pktend_at = -1;
  int          exp_pktend = 0;
  int          k = 0;          // enabled cycles since EN rose
  int          acc = 0;        // words since last packet commit
  int          fill = 0;       // words held while the endpoint is blocked
  int          exp_drop = 0;
  bit          drop_mode = 0;
  bit          flagb_rand = 0;

  always @(posedge ADC_CLK) cyc++;

  // Output monitor on the falling edge.
  always @(negedge ADC_CLK) begin
    if (RST_N) begin
      if (!FX2_SLWR) begin
        obs_q.push_back(FD_OUT);
        obs_t.push_back(cyc);
      end
      if (!FX2_PKTEND) begin
        pktend_cnt++;
        pktend_at = obs_q.size();
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  // Reference model: a frame is captured on every enabled cycle whose index
  // since EN rose is a multiple of max(DECIM+1, channels).
  task automatic model_frame();
    int w;
    if (drop_mode && (fill + NC > DEP)) begin
      exp_drop++;
    end else begin
      for (int c = 0; c < NC; c++) begin
        w = int'(D_IN[c*SW +: SW]) * (1 << (16 - SW)) + ((c == 0) ? 2 : 0) + int'(OTR[c]);
        exp_q.push_back(16'(w));
      end
      fill += NC;
      acc  += NC;
    end
  endtask

  // Driver: one clock cycle of stimulus.
  task automatic step(input logic en_v, input logic rnd);
    int per;
    if (rnd) begin
      for (int c = 0; c < NC; c++) D_IN[c*SW +: SW] = SW'($urandom_range(0, (1 << SW) - 1));
      OTR = NC'($urandom_range(0, (1 << NC) - 1));
    end
    if (flagb_rand) FX2_FLAGB = ($urandom_range(0, 3) != 0);
    EN  = en_v;
    per = (int'(DECIM) + 1 > NC) ? int'(DECIM) + 1 : NC;
    if (en_v) begin
      if (k % per == 0) model_frame();
      k++;
    end else begin
      k = 0;
    end
    @(posedge ADC_CLK);
    #1;
  endtask

  // EN low long enough to drain; a partial packet must then be committed.
  task automatic gap(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1);
    if (acc % PKTW != 0) exp_pktend++;
    acc = 0;
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk(tag, 32'(obs_q[i]), 32'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
    obs_t.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_fd"},       32'(FD_OUT),     32'h0);
    chk({tag, "_slwr"},     32'(FX2_SLWR),   32'h1);
    chk({tag, "_pktend"},   32'(FX2_PKTEND), 32'h1);
    chk({tag, "_fifoadr"},  32'(FIFOADR),    32'h2);
    chk({tag, "_overflow"}, 32'(OVERFLOW),   32'h0);
    chk({tag, "_drop"},     32'(DROP_CNT),   32'h0);
    chk({tag, "_state"},    32'(dbg_state),  32'(ST_IDLE));
  endtask

  initial begin
    RST_N = 1'b0; EN = 1'b0; DECIM = 8'd0; D_IN = '0; OTR = '0; FX2_FLAGB = 1'b1;

    // Reset state
    repeat (3) @(posedge ADC_CLK);
    #1;
    check_reset_outputs("reset");
    RST_N = 1'b1;
    step(1'b0, 1'b0);

    // Fixed frame pattern, latency, 10 words then partial-packet commit
    DECIM = 8'd7;
    D_IN  = {14'h0001, 14'h3CC4};
    OTR   = 2'b10;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("latency_early_slwr", 32'(FX2_SLWR), 32'h1);
    step(1'b1, 1'b0);
    chk("latency_slwr", 32'(FX2_SLWR), 32'h0);
    chk("latency_word", 32'(FD_OUT), 32'hF312);
    for (int i = 0; i < 37; i++) step(1'b1, 1'b0);
    gap(30);
    chk("spacing", (obs_t.size() >= 3) ? 32'(obs_t[2] - obs_t[0]) : 32'hFFFF, 32'd8);
    chk("pktend_after_words", 32'(pktend_at), 32'd10);
    check_stream("fixed");
    chk("pktend_fixed", 32'(pktend_cnt), 32'(exp_pktend));

    // Exactly one full packet: auto-commit, no PKTEND
    DECIM = 8'd1;
    for (int i = 0; i < 256; i++) step(1'b1, 1'b1);
    gap(40);
    check_stream("full_pkt");
    chk("pktend_full_pkt", 32'(pktend_cnt), 32'(exp_pktend));

    // Random bursts with random endpoint back-pressure
    flagb_rand = 1;
    for (int b = 0; b < 4; b++) begin
      int n;
      DECIM = 8'($urandom_range(3, 20));
      n = $urandom_range(20, 80);
      for (int i = 0; i < n; i++) step(1'b1, 1'b1);
      gap(60);
    end
    flagb_rand = 0;
    FX2_FLAGB  = 1'b1;
    step(1'b0, 1'b1);
    check_stream("rand");
    chk("pktend_rand", 32'(pktend_cnt), 32'(exp_pktend));
    chk("overflow_rand", 32'(OVERFLOW), 32'h0);
    chk("drop_rand", 32'(DROP_CNT), 32'(exp_drop));

    // Endpoint blocked: FIFO fills, whole frames dropped, order preserved
    DECIM = 8'd0;
    FX2_FLAGB = 1'b0;
    drop_mode = 1;
    fill = 0;
    for (int i = 0; i < 600; i++) step(1'b1, 1'b1);
    chk("drop_cnt", 32'(DROP_CNT), 32'(exp_drop));
    chk("drop_expected_44", 32'(exp_drop), 32'd44);
    chk("overflow_set", 32'(OVERFLOW), 32'h1);
    chk("no_words_while_blocked", 32'(obs_q.size()), 32'd0);
    drop_mode = 0;
    FX2_FLAGB = 1'b1;
    gap(700);
    check_stream("drain");
    chk("overflow_sticky", 32'(OVERFLOW), 32'h1);
    chk("pktend_drain", 32'(pktend_cnt), 32'(exp_pktend));

    // Reset in the middle of a packet
    DECIM = 8'd3;
    for (int i = 0; i < 30; i++) step(1'b1, 1'b1);
    #3;
    RST_N = 1'b0;
    EN = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(posedge ADC_CLK);
    #1;
    obs_q.delete(); exp_q.delete(); obs_t.delete();
    acc = 0; k = 0; pktend_cnt = 0; exp_pktend = 0; exp_drop = 0;
    RST_N = 1'b1;
    gap(30);
    chk("post_reset_no_slwr", 32'(obs_q.size()), 32'd0);
    chk("post_reset_no_pktend", 32'(pktend_cnt), 32'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
    gap(20);
    check_stream("post_reset");
    chk("pktend_post_reset", 32'(pktend_cnt), 32'(exp_pktend));
    chk("drop_post_reset", 32'(DROP_CNT), 32'(exp_drop));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adc_stream_packer.md
ADC_STREAM_PACKER -- requirements
Module: adc_stream_packer

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, meaning ADC channel count (1..4).
REQ-002 SHALL have parameter SAMPLE_W, default 14, meaning ADC sample width (8..14).
REQ-003 SHALL have parameter DEPTH, default 512, meaning FIFO words (power of 2, >=16).
REQ-004 SHALL have parameter PKT_WORDS, default 256, meaning FX2 packet length in words.
REQ-005 SHALL have port ADC_CLK, input, 1, meaning the single clock; FX2 interface is synchronous to it.
REQ-006 SHALL have port RST_N, input, 1, meaning reset; asynchronous, active-low.
REQ-007 SHALL have port EN, input, 1, meaning capture enable.
REQ-008 SHALL have port DECIM, input, 8, meaning capture period minus one, in cycles.
REQ-009 SHALL have port D_IN, input, NUM_CH*SAMPLE_W, meaning samples; ch0 in LSBs.
REQ-010 SHALL have port OTR, input, NUM_CH, meaning per-channel out-of-range.
REQ-011 SHALL have port FX2_FLAGB, input, 1, meaning EP not full (1 = room).
REQ-012 SHALL have port FD_OUT, output, 16, meaning FX2 data word.
REQ-013 SHALL have port FX2_SLWR, output, 1, meaning write strobe, active-low.
REQ-014 SHALL have port FX2_PKTEND, output, 1, meaning packet commit, active-low.
REQ-015 SHALL have port FIFOADR, output, 2, meaning endpoint select, constant 2'b10.
REQ-016 SHALL have port OVERFLOW, output, 1, meaning sticky frame-drop flag.
REQ-017 SHALL have port DROP_CNT, output, 16, meaning dropped frames, saturating.

Function
REQ-018 Capture tick SHALL fire every max(DECIM+1, NUM_CH) cycles while EN=1; counter restarts at 0 on EN rising.
REQ-019 On a tick, all channels SHALL be latched same cycle, then pushed ch0..chN-1 on consecutive cycles.
REQ-020 Word format SHALL be: sample MSB-justified into [15:16-SAMPLE_W]; bit1 = 1 only for ch0 (frame marker); bit0 = OTR; other low bits 0.
REQ-021 If FIFO free space < NUM_CH at the tick, the whole frame SHALL be dropped, OVERFLOW set, DROP_CNT +1 (saturate at 16'hFFFF); no partial frames ever.
REQ-022 Push and pop in same cycle SHALL leave level unchanged; pop on empty SHALL never occur.
REQ-023 Writer FSM states SHALL be IDLE, WRITE, FLUSH.
REQ-024 IDLE->WRITE when FIFO non-empty and FX2_FLAGB=1; in WRITE, each cycle with FIFO non-empty and FLAGB=1 SHALL pop one word, drive FD_OUT and FX2_SLWR=0 registered one cycle later.
REQ-025 WRITE SHALL hold (SLWR=1, FD_OUT stable) while FLAGB=0 or FIFO empty.
REQ-026 Packet word counter SHALL wrap at PKT_WORDS with no PKTEND (FX2 auto-commit).
REQ-027 When EN=0, FIFO empty and counter !=0: WRITE->FLUSH, FX2_PKTEND=0 for exactly one cycle, counter cleared, ->IDLE.
REQ-028 FLUSH SHALL not be entered when counter=0.
REQ-029 Latency from tick to first SLWR low SHALL be 3 cycles given FLAGB=1 and FIFO empty.
REQ-030 OVERFLOW SHALL clear only on reset.

Reset
REQ-031 On RST_N=0: FD_OUT=16'h0000, FX2_SLWR=1, FX2_PKTEND=1, FIFOADR=2'b10, OVERFLOW=0, DROP_CNT=0, FIFO empty, FSM IDLE, all counters 0.
REQ-032 Reset mid-frame or mid-packet SHALL discard all data with no PKTEND issued.

Structure
REQ-033 Shared package SHALL hold writer-state encoding, FIFOADR endpoint constant, word-format bit positions.
REQ-034 FIFO SHALL be a sub-module sync_fifo (parameters DEPTH, width 16, level output).

Verification
REQ-035 NUM_CH=2, DECIM=7, D_IN ch0=14'h3CC4, ch1=14'h0001, OTR=2'b10 -> words 16'hF312, 16'h0005 alternating every 8 cycles.
REQ-036 FX2_FLAGB=0 for 600 cycles at DECIM=0, NUM_CH=2 -> OVERFLOW=1, DROP_CNT = ticks minus 256, FIFO order intact after FLAGB=1.
REQ-037 EN low after 10 words, PKT_WORDS=256 -> 10 SLWR pulses then one PKTEND pulse.
REQ-038 Exactly 256 words then EN low -> no PKTEND.
REQ-039 RST_N low mid-packet -> outputs at reset values next cycle, no SLWR or PKTEND after release until new tick.
